instrumented_adder_measure: RTL and testbench

INSTRUMENTED_ADDER_MEASURE -- requirements
Module: instrumented_adder_measure

---
 rtl/instr_adder_pkg.sv | 20 ++
 rtl/instrumented_adder_measure_sync_edge_counter.sv | 44 ++++
 rtl/instrumented_adder_measure.sv | 132 +++++++++++++
 tb/tb_instrumented_adder_measure.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_adder_pkg.sv
// Purpose: shared types and defaults for the instrumented adder measurement block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Cycles spent in ARM so the ring-tap synchroniser flushes stale samples.
  localparam int ARM_CYCLES = 2;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/instrumented_adder_measure_sync_edge_counter.sv
// Purpose: synchronise an async ring tap, detect rising edges, count them with saturation.
// Latency: an edge on ring reaches the counter 3 clk edges later (2 sync flops + edge register).
// Backpressure: none; edges arriving while en is low are dropped.
// Ports: clk/rst_n clock and async active-low reset; ring async tap; en count gate;
//        clr synchronous clear of count and overflow; count/overflow results.
module sync_edge_counter
  import instr_adder_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ring,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // sync[0..1] is the synchroniser, sync[2] holds the previous synchronised value.
  logic [2:0] sync;
  logic       rise;

  assign rise = sync[1] & ~sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      sync <= {sync[1:0], ring};
      if (clr) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (en && rise) begin
        // At all-ones the count holds and the lost edge is flagged instead.
        if (&count) overflow <= 1'b1;
        else        count    <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instrumented_adder_measure.sv
// Purpose: measure one adder channel by counting its ring-oscillator edges over a cycle window.
// Latency: done rises window+3 cycles after an accepted start (1 accept, 2 ARM, window RUN); 1 cycle for window=0.
// Backpressure: start is ignored while busy; active low aborts and holds control outputs idle.
// Ports: wb_clk_i/wb_rst_n_i clock and async active-low reset; active enable; start/ch_sel/window/a_in/b_in
//        request; a_out/b_out operands to channels; ring_en/ring_in ring control and taps; sum_in channel sums;
//        count/sum_out results; busy/done/overflow status.
module instrumented_adder_measure
  import instr_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  // Width of the window port and counter; follows CNT_W unless overridden.
  parameter int WIN_W  = CNT_W,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    active,
  input  logic                    start,
  input  logic [SEL_W-1:0]        ch_sel,
  input  logic [WIN_W-1:0]        window,
  input  logic [WIDTH-1:0]        a_in,
  input  logic [WIDTH-1:0]        b_in,
  output logic [WIDTH-1:0]        a_out,
  output logic [WIDTH-1:0]        b_out,
  output logic [NUM_CH-1:0]       ring_en,
  input  logic [NUM_CH-1:0]       ring_in,
  input  logic [NUM_CH*WIDTH-1:0] sum_in,
  output logic [CNT_W-1:0]        count,
  output logic [WIDTH-1:0]        sum_out,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  // Reset asserts asynchronously but releases two clock edges after wb_rst_n_i rises.
  logic [1:0] rst_q;
  logic       rst_sync_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_q <= 2'b00;
    else             rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_sync_n = rst_q[1];

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [WIN_W-1:0] win_cnt;
  logic [1:0]       arm_cnt;
  logic             accept;
  logic             run_en;
  logic             ring_sel;

  assign accept   = active && start && ((state == ST_IDLE) || (state == ST_DONE));
  assign run_en   = active && (state == ST_RUN);
  // sel is clamped on accept, so it always indexes an existing channel.
  assign ring_sel = ring_in[sel];

  always_ff @(posedge wb_clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state   <= ST_IDLE;
      sel     <= '0;
      win_cnt <= '0;
      arm_cnt <= '0;
      a_out   <= '0;
      b_out   <= '0;
      sum_out <= '0;
      ring_en <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (!active) begin
      // Abort: control outputs go idle, measured data and operands are kept.
      state   <= ST_IDLE;
      ring_en <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            sel     <= (int'(ch_sel) >= NUM_CH) ? '0 : ch_sel;
            win_cnt <= window;
            a_out   <= a_in;
            b_out   <= b_in;
            arm_cnt <= '0;
            if (window == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ARM;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        ST_ARM: begin
          arm_cnt <= arm_cnt + 2'd1;
          if (arm_cnt == 2'(ARM_CYCLES - 1)) begin
            state   <= ST_RUN;
            ring_en <= NUM_CH'(1) << sel;
          end
        end
        ST_RUN: begin
          win_cnt <= win_cnt - WIN_W'(1);
          if (win_cnt == WIN_W'(1)) begin
            sum_out <= sum_in[int'(sel)*WIDTH +: WIDTH];
            ring_en <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (wb_clk_i),
    .rst_n    (rst_sync_n),
    .ring     (ring_sel),
    .en       (run_en),
    .clr      (accept),
    .count    (count),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_instrumented_adder_measure.sv
// Purpose: directed self-checking bench for instrumented_adder_measure (default build plus a 3-channel, 4-bit-count build).
// Latency: inputs driven and outputs sampled on the falling clock edge; k counts rising edges after an accept.
// Backpressure: n/a.
module tb_instrumented_adder_measure;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, active;

  // Build A: defaults (WIDTH 32, NUM_CH 4, CNT_W 32).
  logic         start_a;
  logic [1:0]   ch_a;
  logic [31:0]  win_a, a_in, b_in;
  logic [31:0]  a_out_a, b_out_a, count_a, sum_out_a;
  logic [3:0]   ring_en_a, ring_a, tog_a;
  logic [127:0] sum_a;
  logic         busy_a, done_a, ovf_a;

  // Build B: NUM_CH 3, CNT_W 4, 8-bit window.
  logic         start_b;
  logic [1:0]   ch_b;
  logic [7:0]   win_b;
  logic [31:0]  a_out_b, b_out_b, sum_out_b;
  logic [3:0]   count_b;
  logic [2:0]   ring_en_b, ring_b, tog_b;
  logic [95:0]  sum_b;
  logic         busy_b, done_b, ovf_b;

  int total = 0, passed = 0, failed = 0;
  int nb, bad;
  logic [31:0] a_v, b_v;

  // Per-channel adder models: each channel adds a distinct offset so a wrong mux pick is visible.
  function automatic logic [31:0] bias(input int k);
    case (k)
      0:       return 32'd5;
      1:       return 32'd7;
      2:       return 32'd0;
      default: return 32'd3;
    endcase
  endfunction

  always_comb begin
    sum_a = '0;
    for (int k = 0; k < 4; k++) sum_a[k*32 +: 32] = a_out_a + b_out_a + bias(k);
  end

  always_comb begin
    sum_b = '0;
    for (int k = 0; k < 3; k++) sum_b[k*32 +: 32] = a_out_b + b_out_b + bias(k);
  end

  instrumented_adder_measure u_dut_a (
    .wb_clk_i (clk), .wb_rst_n_i (rst_n), .active (active), .start (start_a),
    .ch_sel (ch_a), .window (win_a), .a_in (a_in), .b_in (b_in),
    .a_out (a_out_a), .b_out (b_out_a), .ring_en (ring_en_a), .ring_in (ring_a),
    .sum_in (sum_a), .count (count_a), .sum_out (sum_out_a),
    .busy (busy_a), .done (done_a), .overflow (ovf_a)
  );

  instrumented_adder_measure #(.NUM_CH(3), .CNT_W(4), .WIN_W(8)) u_dut_b (
    .wb_clk_i (clk), .wb_rst_n_i (rst_n), .active (active), .start (start_b),
    .ch_sel (ch_b), .window (win_b), .a_in (a_in), .b_in (b_in),
    .a_out (a_out_b), .b_out (b_out_b), .ring_en (ring_en_b), .ring_in (ring_b),
    .sum_in (sum_b), .count (count_b), .sum_out (sum_out_b),
    .busy (busy_b), .done (done_b), .overflow (ovf_b)
  );

  // Advance to the next falling edge; toggling every cycle gives one ring rising edge per two clocks.
  task automatic tick();
    @(negedge clk);
    ring_a = ring_a ^ tog_a;
    ring_b = ring_b ^ tog_b;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; active = 1'b1;
    start_a = 1'b0; ch_a = '0; win_a = '0; a_in = '0; b_in = '0;
    start_b = 1'b0; ch_b = '0; win_b = '0;
    ring_a = '0; ring_b = '0; tog_a = 4'b0010; tog_b = 3'b001;

    // Reset state.
    repeat (3) tick();
    chk("reset_ctrl_a", {busy_a, done_a, ovf_a, ring_en_a}, 0);
    chk("reset_data_a", {count_a, sum_out_a}, 0);
    chk("reset_ops_a", {a_out_a, b_out_a}, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_after_release", {busy_a, done_a, busy_b, done_b}, 0);

    // Window 10 on channel 1: ARM k=1..2, RUN k=3..12, DONE from k=13.
    a_v = 32'h1234_0000; b_v = 32'h0000_5678;
    start_a = 1'b1; ch_a = 2'd1; win_a = 32'd10; a_in = a_v; b_in = b_v;
    nb = 0; bad = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      start_a = 1'b0;
      if (busy_a) nb++;
      if (busy_a !== (k <= 12)) bad++;
      if (ring_en_a !== (((k >= 3) && (k <= 12)) ? 4'b0010 : 4'b0000)) bad++;
      if (done_a !== (k >= 13)) bad++;
    end
    chk("w10_busy_cycles", nb, 12);
    chk("w10_timing_errors", bad, 0);
    chk("w10_done", done_a, 1);
    chk("w10_count_5pm1", ((count_a >= 4) && (count_a <= 6)), 1);
    chk("w10_sum_out", sum_out_a, a_v + b_v + 32'd7);
    chk("w10_ovf", ovf_a, 0);

    // Window 0 from DONE: done one cycle after accept, count cleared, ring never enabled.
    start_a = 1'b1; win_a = 32'd0;
    tick();
    start_a = 1'b0;
    chk("w0_status", {done_a, busy_a, ring_en_a}, 6'b100000);
    chk("w0_count", count_a, 0);

    // Carry-out wraps: channel 2 sum is zero; done lands exactly at k=6 for window 3.
    tog_a = 4'b0000;
    start_a = 1'b1; ch_a = 2'd2; win_a = 32'd3; a_in = 32'hFFFF_FFFF; b_in = 32'd1;
    repeat (5) begin tick(); start_a = 1'b0; end
    chk("wrap_not_done_k5", done_a, 0);
    tick();
    chk("wrap_done_k6", done_a, 1);
    chk("wrap_sum_out", sum_out_a, 0);
    chk("wrap_operands", {a_out_a, b_out_a}, {32'hFFFF_FFFF, 32'd1});
    chk("wrap_count", count_a, 0);

    // Abort: active drops in RUN cycle 3 (k=5); only samples at k=4,5 count, giving one edge.
    tog_a = 4'b0010;
    start_a = 1'b1; ch_a = 2'd1; win_a = 32'd10; a_in = 32'h10; b_in = 32'h20;
    repeat (5) begin tick(); start_a = 1'b0; end
    active = 1'b0;
    tick();
    chk("abort_status", {busy_a, done_a, ring_en_a}, 0);
    chk("abort_count", count_a, 1);
    tog_a = 4'b1000;
    repeat (2) tick();
    chk("abort_count_held", count_a, 1);
    active = 1'b1;
    tick();
    // Restart: window 4 on channel 3, done at k=7 with four samples -> two edges.
    start_a = 1'b1; ch_a = 2'd3; win_a = 32'd4; a_in = 32'h100; b_in = 32'h200;
    repeat (7) begin tick(); start_a = 1'b0; end
    chk("restart_done", {done_a, busy_a}, 2'b10);
    chk("restart_count", count_a, 2);
    chk("restart_sum_out", sum_out_a, 32'h303);

    // Start while busy is ignored: window stays 6 (busy k=1..8) and operands stay.
    start_a = 1'b1; ch_a = 2'd1; win_a = 32'd6; a_in = 32'hA1; b_in = 32'hB1;
    nb = 0;
    tick();
    if (busy_a) nb++;
    start_a = 1'b1; win_a = 32'd20; a_in = 32'hEE; b_in = 32'hFF;
    for (int k = 2; k <= 10; k++) begin
      tick();
      start_a = 1'b0;
      if (busy_a) nb++;
    end
    chk("busy_start_ignored", nb, 8);
    chk("busy_start_ops", {a_out_a, b_out_a}, {32'hA1, 32'hB1});

    // Reset mid-RUN: outputs clear without waiting for a clock edge.
    start_a = 1'b1; win_a = 32'd10; a_in = 32'h55; b_in = 32'h66;
    repeat (4) begin tick(); start_a = 1'b0; end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_run_ctrl", {busy_a, done_a, ovf_a, ring_en_a}, 0);
    chk("rst_mid_run_data", {count_a, sum_out_a, a_out_a, b_out_a}, 0);
    repeat (2) tick();
    // Release: a start held high is seen only on the third rising edge after release.
    rst_n = 1'b1; start_a = 1'b1; win_a = 32'd0;
    tick();
    chk("rel_edge1", done_a, 0);
    tick();
    chk("rel_edge2", done_a, 0);
    tick();
    chk("rel_edge3", done_a, 1);
    start_a = 1'b0;

    // Build B: ch_sel 3 on 3 channels maps to channel 0; 20 edges saturate a 4-bit count.
    tog_b = 3'b001;
    start_b = 1'b1; ch_b = 2'd3; win_b = 8'd40; a_in = 32'h4000; b_in = 32'h0020;
    bad = 0;
    for (int k = 1; k <= 44; k++) begin
      tick();
      start_b = 1'b0;
      if (ring_en_b !== (((k >= 3) && (k <= 42)) ? 3'b001 : 3'b000)) bad++;
      if (done_b !== (k >= 43)) bad++;
    end
    chk("sat_timing_errors", bad, 0);
    chk("sat_count", count_b, 4'hF);
    chk("sat_overflow", ovf_b, 1);
    chk("sat_sum_out_ch0", sum_out_b, 32'h4025);
    start_b = 1'b1; win_b = 8'd2;
    tick();
    start_b = 1'b0;
    chk("sat_cleared_on_accept", {busy_b, ovf_b, count_b}, 6'b100000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
